// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus bundle: hazard/redirect inputs, imem port, IF/ID outputs
interface if_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_done;
    logic        align_err;

    modport master (
        input  stall, redirect, redirect_pc, instr_in,
        output pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_done, align_err
    );

    modport slave (
        output stall, redirect, redirect_pc, instr_in,
        input  pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_done, align_err
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, imem address, IF/ID register, redirect/stall/limit handling
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_WORDS = 200
) (
    input  logic     clk,
    input  logic     rst_n,
    if_stage_if.master bus
);
    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        align_err;
    logic        done;

    assign pc_next_seq = pc + 32'd4;
    assign done        = (pc >= LIMIT);

    // Priority: redirect kills even a stalled IF/ID, then stall, then drain at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            align_err  <= 1'b0;
        end else if (bus.redirect) begin
            pc         <= {bus.redirect_pc[31:2], 2'b00};
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                align_err <= 1'b1;
            end
        end else if (bus.stall) begin
            pc         <= pc;
        end else if (done) begin
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_next_seq;
            ifid_instr <= bus.instr_in;
            ifid_pc4   <= pc_next_seq;
            ifid_valid <= 1'b1;
        end
    end

    assign bus.pc_out     = pc;
    assign bus.ifid_instr = ifid_instr;
    assign bus.ifid_pc4   = ifid_pc4;
    assign bus.ifid_valid = ifid_valid;
    assign bus.fetch_done = done;
    assign bus.align_err  = align_err;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage (default depth and a 4-word limit instance)
module tb_if_stage;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   failures;
    logic [31:0] mem [0:63];

    if_stage_if ba ();
    if_stage_if bb ();

    if_stage #(.RESET_PC(32'd0), .IMEM_WORDS(200)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ba));
    if_stage #(.RESET_PC(32'd0), .IMEM_WORDS(4))   dut_b (.clk(clk), .rst_n(rst_b), .bus(bb));

    assign ba.instr_in = mem[ba.pc_out[7:2]];
    assign bb.instr_in = mem[bb.pc_out[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_pc", ba.pc_out, 32'd0);
        chk("reset_instr", ba.ifid_instr, 32'd0);
        chk("reset_pc4", ba.ifid_pc4, 32'd0);
        chk("reset_valid", {31'd0, ba.ifid_valid}, 32'd0);
        chk("reset_done", {31'd0, ba.fetch_done}, 32'd0);
        chk("reset_align", {31'd0, ba.align_err}, 32'd0);
        rst_a = 1'b1;
    endtask

    task automatic test_straight_fetch();
        for (int i = 0; i < 3; i++) begin
            chk("seq_pc", ba.pc_out, 32'(4 * i));
            @(negedge clk);
            chk("seq_instr", ba.ifid_instr, mem[i]);
            chk("seq_pc4", ba.ifid_pc4, 32'(4 * (i + 1)));
            chk("seq_valid", {31'd0, ba.ifid_valid}, 32'd1);
        end
    endtask

    task automatic test_stall();
        ba.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_pc", ba.pc_out, 32'd12);
            chk("stall_instr", ba.ifid_instr, mem[2]);
            chk("stall_pc4", ba.ifid_pc4, 32'd12);
            chk("stall_valid", {31'd0, ba.ifid_valid}, 32'd1);
        end
        ba.stall = 1'b0;
        @(negedge clk);
        chk("unstall_pc", ba.pc_out, 32'd16);
        chk("unstall_instr_zero_word", ba.ifid_instr, mem[3]);
        chk("unstall_valid", {31'd0, ba.ifid_valid}, 32'd1);
        @(negedge clk);
        chk("after_pc", ba.pc_out, 32'd20);
        chk("after_instr", ba.ifid_instr, mem[4]);
    endtask

    task automatic test_redirect_stall();
        ba.redirect    = 1'b1;
        ba.redirect_pc = 32'd8;
        ba.stall       = 1'b1;
        @(negedge clk);
        ba.redirect = 1'b0;
        ba.stall    = 1'b0;
        chk("rs_pc", ba.pc_out, 32'd8);
        chk("rs_bubble_valid", {31'd0, ba.ifid_valid}, 32'd0);
        chk("rs_bubble_instr", ba.ifid_instr, 32'd0);
        @(negedge clk);
        chk("rs_next_instr", ba.ifid_instr, mem[2]);
        chk("rs_next_pc4", ba.ifid_pc4, 32'd12);
        chk("rs_next_valid", {31'd0, ba.ifid_valid}, 32'd1);
    endtask

    task automatic test_misaligned();
        ba.redirect    = 1'b1;
        ba.redirect_pc = 32'h0000_0016;
        @(negedge clk);
        ba.redirect = 1'b0;
        chk("mis_pc", ba.pc_out, 32'h14);
        chk("mis_align", {31'd0, ba.align_err}, 32'd1);
        @(negedge clk);
        chk("mis_fetch_instr", ba.ifid_instr, mem[5]);
        chk("mis_fetch_pc", ba.pc_out, 32'd24);
        chk("mis_sticky", {31'd0, ba.align_err}, 32'd1);
    endtask

    task automatic test_async_reset();
        chk("ar_pre_pc", ba.pc_out, 32'd24);
        #2;
        rst_a = 1'b0;
        #1;
        chk("ar_pc", ba.pc_out, 32'd0);
        chk("ar_valid", {31'd0, ba.ifid_valid}, 32'd0);
        chk("ar_align", {31'd0, ba.align_err}, 32'd0);
        @(negedge clk);
        chk("ar_hold_pc", ba.pc_out, 32'd0);
        rst_a = 1'b1;
    endtask

    task automatic test_fetch_limit();
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lim_notdone", {31'd0, bb.fetch_done}, 32'd0);
            @(negedge clk);
        end
        chk("lim_pc", bb.pc_out, 32'd16);
        chk("lim_done", {31'd0, bb.fetch_done}, 32'd1);
        chk("lim_last_instr", bb.ifid_instr, mem[3]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("lim_frozen_pc", bb.pc_out, 32'd16);
            chk("lim_drain_valid", {31'd0, bb.ifid_valid}, 32'd0);
        end
        bb.redirect    = 1'b1;
        bb.redirect_pc = 32'd0;
        @(negedge clk);
        bb.redirect = 1'b0;
        chk("lim_redir_done", {31'd0, bb.fetch_done}, 32'd0);
        chk("lim_redir_pc", bb.pc_out, 32'd0);
        @(negedge clk);
        chk("lim_restart_instr", bb.ifid_instr, mem[0]);
        chk("lim_restart_valid", {31'd0, bb.ifid_valid}, 32'd1);
        chk("lim_restart_pc", bb.pc_out, 32'd4);
    endtask

    // Reference: PC and IF/ID contents described as the architectural effect of each cycle.
    task automatic test_random();
        logic [31:0] m_pc, m_instr, m_pc4, tgt;
        logic        m_valid, m_align, r, s;
        int          fail_before;
        fail_before = failures;
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_align = 0;
        for (int n = 0; n < 400; n++) begin
            chk("rnd_pc", bb.pc_out, m_pc);
            chk("rnd_instr", bb.ifid_instr, m_instr);
            chk("rnd_pc4", bb.ifid_pc4, m_pc4);
            chk("rnd_flags", {29'd0, bb.ifid_valid, bb.fetch_done, bb.align_err},
                {29'd0, m_valid, (m_pc >= 32'd16), m_align});
            if (failures - fail_before > 10) break;
            r   = ($urandom_range(0, 7) == 0);
            s   = ($urandom_range(0, 3) == 0);
            tgt = 32'($urandom_range(0, 31));
            if (n > 300) tgt = tgt & 32'hFFFF_FFFC;
            bb.redirect = r; bb.stall = s; bb.redirect_pc = tgt;
            if (r) begin
                m_pc = tgt & ~32'd3;
                m_instr = 0; m_pc4 = 0; m_valid = 0;
                if (tgt % 4 != 0) m_align = 1;
            end else if (!s) begin
                if (m_pc >= 32'd16) begin
                    m_instr = 0; m_pc4 = 0; m_valid = 0;
                end else begin
                    m_instr = mem[m_pc / 4];
                    m_pc    = m_pc + 4;
                    m_pc4   = m_pc;
                    m_valid = 1;
                end
            end
            @(negedge clk);
        end
        bb.redirect = 0; bb.stall = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        mem[3] = 32'd0;
        ba.stall = 0; ba.redirect = 0; ba.redirect_pc = 0;
        bb.stall = 0; bb.redirect = 0; bb.redirect_pc = 0;
        rst_a = 0; rst_b = 0;
        test_reset();
        test_straight_fetch();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_async_reset();
        test_fetch_limit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the instruction-memory read address, and captures the returned instruction into the IF/ID pipeline register. It handles hazard stalls from ID, branch/jump redirects from EX, and end-of-program detection. The instruction memory is a combinational read: the word for `pc_out` is valid on `instr_in` within the same cycle.

## Interface
- `RESET_PC`, 32'd0, PC value loaded on reset.
- `IMEM_WORDS`, 200, instruction-memory depth in 32-bit words. The fetch limit is `IMEM_WORDS*4` bytes.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard hold from ID (load-use); freezes PC and IF/ID.
- `redirect`  in  1  taken branch/jump from EX.
- `redirect_pc`  in  32  byte target address, valid with `redirect`.
- `instr_in`  in  32  instruction word from instruction memory for `pc_out`.
- `pc_out`  out  32  registered PC; drives the instruction-memory address.
- `ifid_instr`  out  32  IF/ID instruction.
- `ifid_pc4`  out  32  IF/ID PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `fetch_done`  out  1  PC is at or beyond the fetch limit.
- `align_err`  out  1  sticky; a redirect target had nonzero bits [1:0].

## Operation
- **Reset (async, `rst_n`=0):**
  - `pc_out`=`RESET_PC`.
  - `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0.
  - `fetch_done`=0, `align_err`=0.
  - Outputs hold these values while reset is asserted. Reset asserted mid-operation discards all in-flight state immediately.
- **Edge priority:** redirect > stall > done-hold > normal fetch.
- **Normal fetch** (pc < limit, no stall, no redirect):
  - pc ← pc+4.
  - IF/ID ← {`instr_in`, pc+4, valid=1}.
- **Stall** (no redirect): pc, `ifid_instr`, `ifid_pc4` and `ifid_valid` all hold.
- **Redirect** (overrides stall):
  - pc ← {`redirect_pc`[31:2], 2'b00}.
  - IF/ID ← bubble (instr=0, pc4=0, valid=0), which flushes the wrong-path instruction.
  - If `redirect_pc`[1:0]≠0, set `align_err`=1 (sticky until reset).
- **Fetch limit:**
  - `fetch_done` = (pc ≥ `IMEM_WORDS*4`), decoded combinationally from the registered PC.
  - While done, with no redirect: pc holds, and IF/ID loads a bubble each non-stalled cycle, so the pipeline drains.
  - A redirect to an in-range target clears done on the next cycle.
  - A redirect to an out-of-range target gives done=1 on the next cycle.
- **Arithmetic:** all PC arithmetic is 32-bit unsigned. pc+4 wraps modulo 2^32, which is unreachable when the limit is below 2^32.
- **Instruction word 32'd0:** treated as an ordinary instruction and captured with valid=1. Only the limit ends fetching.

## Timing
- `pc_out` changes only on the rising edge (or on async reset).
- Latency: the word at address A appears on `ifid_instr` one edge after the cycle in which `pc_out`=A, with `ifid_pc4`=A+4.
- **Redirect penalty:**
  - Redirect sampled at edge N: the target is on `pc_out` after edge N.
  - Its instruction is in IF/ID after edge N+1.
  - `ifid_valid` is 0 for exactly one cycle.
- **Stall:** a stall held for k cycles freezes all outputs for k cycles. Fetch resumes on the first edge where `stall`=0.
- **Redirect and stall in the same cycle:** redirect wins. The stalled IF/ID content is killed, because ID must re-evaluate the new path.
- Back-to-back redirects: each is honoured. Only the last target is fetched.

## Test plan
- **Reset and straight-line fetch:** release `rst_n` with memory words 0..5 loaded.
  - Expect `pc_out` 0,4,8,…
  - `ifid_instr` equals word i one cycle later, with `ifid_pc4`=4(i+1) and valid=1.
- **Stall:** assert `stall` for 2 cycles while pc=12.
  - Expect pc held at 12, and IF/ID held on word 2 with pc4=12.
  - After release, pc=16 and IF/ID=word 3.
- **Redirect with stall:** at pc=20, assert `redirect`=1 with target 8, together with `stall`=1.
  - Expect pc=8 and a bubble (valid=0, instr=0) next cycle.
  - The cycle after that: IF/ID=word 2, pc4=12.
- **Misaligned redirect:** `redirect_pc`=0x0000_0016.
  - Expect pc=0x14 and `align_err`=1.
  - `align_err` stays 1 through later normal fetches until `rst_n`=0.
- **Fetch limit:** with `IMEM_WORDS`=4, run until pc=16.
  - Expect `fetch_done`=1, pc frozen at 16, and valid=0 on subsequent cycles.
  - Redirect to 0: done=0 next cycle and fetch restarts.
- **Async reset mid-run:** drop `rst_n` between edges at pc=24.
  - Expect `pc_out`=`RESET_PC` and `ifid_valid`=0 immediately, before the next edge.
